fan_pwm_driver: RTL

Downstream stage of the PID controller. It converts the signed PID output into a fan PWM waveform. A spin-up state machine forces a full-on kick when the fan starts and enforces a minimum running duty. The block also generates the single-cycle PID sample enable, so control updates stay locked to PWM period boundaries.

---
 rtl/fan_pwm_driver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fan_pwm_driver.sv
// Fan PWM stage: turns the signed PID output into a PWM waveform with a full-on spin-up
// kick and a minimum running duty, and emits the PID sample strobe on period boundaries.
module fan_pwm_driver #(
    parameter int ADC_BITWIDTH   = 8,
    parameter int PWM_PRESCALE   = 4,
    parameter int MIN_DUTY       = 32,
    parameter int KICK_PERIODS   = 16,
    parameter int SAMPLE_PERIODS = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           en_i,
    input  logic signed [ADC_BITWIDTH:0]   PID_value_i,
    output logic                           pwm_o,
    output logic                           clk_en_PID_o,
    output logic [1:0]                     state_o
);

    localparam int PW = (PWM_PRESCALE   > 1) ? $clog2(PWM_PRESCALE)   : 1;
    localparam int KW = (KICK_PERIODS   > 1) ? $clog2(KICK_PERIODS)   : 1;
    localparam int SW = (SAMPLE_PERIODS > 1) ? $clog2(SAMPLE_PERIODS) : 1;

    localparam logic [ADC_BITWIDTH-1:0] CNT_MAX    = '1;
    localparam logic [ADC_BITWIDTH-1:0] MIN_D      = ADC_BITWIDTH'(MIN_DUTY);
    localparam logic [PW-1:0]           PRESC_LAST = PW'(PWM_PRESCALE - 1);
    localparam logic [KW-1:0]           KICK_LAST  = KW'(KICK_PERIODS - 1);
    localparam logic [SW-1:0]           SAMP_LAST  = SW'(SAMPLE_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_presc;
    logic [ADC_BITWIDTH-1:0] r_cnt;
    logic [KW-1:0]           r_kick;
    logic [SW-1:0]           r_samp;
    logic [ADC_BITWIDTH-1:0] r_duty;
    logic                    r_pwm;
    logic                    r_stb;

    logic                    w_tick;
    logic                    w_wrap;
    logic [ADC_BITWIDTH-1:0] w_req;
    logic                    w_req_nz;
    logic [ADC_BITWIDTH-1:0] w_duty_new;
    logic                    w_level;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_wrap = w_tick && (r_cnt == CNT_MAX);

    // Non-positive requests mean "fan off"; positives are already clamped upstream.
    always_comb begin
        w_req = '0;
        if (!PID_value_i[ADC_BITWIDTH] && (PID_value_i[ADC_BITWIDTH-1:0] != '0)) begin
            w_req = PID_value_i[ADC_BITWIDTH-1:0];
        end
    end

    assign w_req_nz   = (w_req != '0);
    assign w_duty_new = (w_req > MIN_D) ? w_req : MIN_D;

    // Full-scale duty must stay high through cnt == max, which cnt < duty would miss.
    always_comb begin
        w_level = 1'b0;
        case (r_state)
            ST_KICK: w_level = 1'b1;
            ST_RUN:  w_level = (r_duty == CNT_MAX) || (r_cnt < r_duty);
            default: w_level = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_OFF;
            r_presc <= '0;
            r_cnt   <= '0;
            r_kick  <= '0;
            r_samp  <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
            r_stb   <= 1'b0;
        end else if (!en_i) begin
            r_state <= ST_OFF;
            r_presc <= '0;
            r_cnt   <= '0;
            r_kick  <= '0;
            r_samp  <= '0;
            r_pwm   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_pwm <= w_level;
            r_stb <= 1'b0;
            if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= r_cnt + ADC_BITWIDTH'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            // Request, state and duty are only looked at on period boundaries.
            if (w_wrap) begin
                if (r_samp == SAMP_LAST) begin
                    r_samp <= '0;
                    r_stb  <= 1'b1;
                end else begin
                    r_samp <= r_samp + SW'(1);
                end
                case (r_state)
                    ST_OFF: begin
                        if (w_req_nz) begin
                            r_state <= ST_KICK;
                            r_kick  <= '0;
                        end
                    end
                    ST_KICK: begin
                        if (!w_req_nz) begin
                            r_state <= ST_OFF;
                        end else if (r_kick == KICK_LAST) begin
                            r_state <= ST_RUN;
                            r_duty  <= w_duty_new;
                        end else begin
                            r_kick <= r_kick + KW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!w_req_nz) begin
                            r_state <= ST_OFF;
                        end else begin
                            r_duty <= w_duty_new;
                        end
                    end
                    default: r_state <= ST_OFF;
                endcase
            end
        end
    end

    assign pwm_o        = r_pwm;
    assign clk_en_PID_o = r_stb;
    assign state_o      = r_state;

endmodule
